inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 187 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: accepts one request, emits one encoded word (or two for a
// wide LI pseudo-op) over a valid/ready handshake from registered outputs.
package inst_encoder_pkg;
    typedef enum logic [3:0] {
        lui, auipc, jal, jalr, branch_type, load_type, store_type,
        imm_arith_type, reg_arith_type, fence_type, system_type, invalid
    } opcode_t;
endpackage

module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  opcode_t     kind,
    input  logic        pseudo_li,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI, EMIT_LO} state_t;

    state_t      state_r, state_s;
    logic [31:0] word_r, word_s;
    logic [31:0] lo_word_r, lo_word_s;
    logic        err_r, err_s;
    logic        valid_r, valid_s;
    logic        ready_r;
    logic [32:0] enc_s;
    logic [31:0] li_sum_s;
    logic        li_fits_s;

    // Returns {error, word}; errors still carry the truncated encoding except for invalid.
    function automatic logic [32:0] encode(input opcode_t k, input logic [4:0] f_rd,
                                           input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        logic        fits12;
        fits12 = (im[31:11] == {21{im[11]}});
        w = 32'h0;
        e = 1'b0;
        case (k)
            lui:   w = {im[31:12], f_rd, 7'b0110111};
            auipc: w = {im[31:12], f_rd, 7'b0010111};
            jal: begin
                w = {im[20], im[10:1], im[11], im[19:12], f_rd, 7'b1101111};
                e = im[0] | (im[31:20] != {12{im[20]}});
            end
            jalr: begin
                w = {im[11:0], f_rs1, 3'b000, f_rd, 7'b1100111};
                e = ~fits12;
            end
            branch_type: begin
                w = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], 7'b1100011};
                e = im[0] | (im[31:12] != {20{im[12]}});
            end
            load_type: begin
                w = {im[11:0], f_rs1, f3, f_rd, 7'b0000011};
                e = ~fits12;
            end
            store_type: begin
                w = {im[11:5], f_rs2, f_rs1, f3, im[4:0], 7'b0100011};
                e = ~fits12;
            end
            imm_arith_type: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    w = {f7, im[4:0], f_rs1, f3, f_rd, 7'b0010011};
                    e = (im[31:5] != 27'd0);
                end else begin
                    w = {im[11:0], f_rs1, f3, f_rd, 7'b0010011};
                    e = ~fits12;
                end
            end
            reg_arith_type: w = {f7, f_rs2, f_rs1, f3, f_rd, 7'b0110011};
            fence_type: begin
                w = {im[11:0], f_rs1, f3, f_rd, 7'b0001111};
                e = ~fits12;
            end
            system_type: begin
                w = {im[11:0], f_rs1, f3, f_rd, 7'b1110011};
                e = ~fits12;
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    // Next-state and next-output logic for the emit sequencer.
    always_comb begin
        state_s   = state_r;
        word_s    = word_r;
        err_s     = err_r;
        valid_s   = valid_r;
        lo_word_s = lo_word_r;
        enc_s     = encode(kind, rd, rs1, rs2, funct3, funct7, imm);
        li_sum_s  = imm + 32'h0000_0800;
        li_fits_s = (imm[31:11] == {21{imm[11]}});
        case (state_r)
            IDLE: begin
                if (in_valid && ready_r) begin
                    valid_s = 1'b1;
                    if (pseudo_li && !li_fits_s) begin
                        state_s   = EMIT_HI;
                        word_s    = {li_sum_s[31:12], rd, 7'b0110111};
                        err_s     = 1'b0;
                        lo_word_s = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
                    end else if (pseudo_li) begin
                        state_s = EMIT;
                        word_s  = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
                        err_s   = 1'b0;
                    end else begin
                        state_s = EMIT;
                        word_s  = enc_s[31:0];
                        err_s   = enc_s[32];
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end
            EMIT, EMIT_LO: begin
                if (out_ready) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    word_s  = 32'h0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            EMIT_HI: begin
                if (out_ready) begin
                    state_s = EMIT_LO;
                    word_s  = lo_word_r;
                    err_s   = 1'b0;
                end else begin
                    state_s = EMIT_HI;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                word_s  = 32'h0;
                err_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending words immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            word_r    <= 32'h0;
            lo_word_r <= 32'h0;
            err_r     <= 1'b0;
            valid_r   <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            word_r    <= word_s;
            lo_word_r <= lo_word_s;
            err_r     <= err_s;
            valid_r   <= valid_s;
            ready_r   <= (state_s == IDLE);
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_word  = word_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against an arithmetic reference model of RV32I encoding.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    opcode_t     kind = lui;
    logic        pseudo_li = 1'b0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_err;

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          exp_n;
    logic [31:0] exp_w [2];
    logic [31:0] exp_e [2];

    inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .kind(kind),
        .pseudo_li(pseudo_li), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input int v, input int bits);
        return (v >= -(1 <<< (bits - 1))) && (v <= (1 <<< (bits - 1)) - 1);
    endfunction

    // Reference model: expected word list from field positions and signed value ranges.
    task automatic model(input opcode_t k, input logic li, input logic [4:0] f_rd,
                         input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        int          s;
        logic [31:0] r, s1, s2, ff3, ff7, ifld, hi;
        s    = $signed(im);
        r    = 32'(f_rd) << 7;
        s1   = 32'(f_rs1) << 15;
        s2   = 32'(f_rs2) << 20;
        ff3  = 32'(f3) << 12;
        ff7  = 32'(f7) << 25;
        ifld = (im & 32'hFFF) << 20;
        exp_n = 1;
        exp_e[0] = 32'd0;
        exp_e[1] = 32'd0;
        if (li) begin
            if (in_rng(s, 12)) begin
                exp_w[0] = ifld | r | 32'h13;
            end else begin
                exp_n = 2;
                hi = (im + 32'h800) >> 12;
                exp_w[0] = (hi << 12) | r | 32'h37;
                exp_w[1] = ifld | (32'(f_rd) << 15) | r | 32'h13;
            end
        end else begin
            case (k)
                lui:   exp_w[0] = (im & 32'hFFFF_F000) | r | 32'h37;
                auipc: exp_w[0] = (im & 32'hFFFF_F000) | r | 32'h17;
                jal: begin
                    exp_w[0] = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                             | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | r | 32'h6F;
                    exp_e[0] = 32'((im[0] == 1'b1) || !in_rng(s, 21));
                end
                jalr: begin
                    exp_w[0] = ifld | s1 | r | 32'h67;
                    exp_e[0] = 32'(!in_rng(s, 12));
                end
                branch_type: begin
                    exp_w[0] = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2 | s1 | ff3
                             | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
                    exp_e[0] = 32'((im[0] == 1'b1) || !in_rng(s, 13));
                end
                store_type: begin
                    exp_w[0] = (((im >> 5) & 32'h7F) << 25) | s2 | s1 | ff3 | ((im & 32'h1F) << 7) | 32'h23;
                    exp_e[0] = 32'(!in_rng(s, 12));
                end
                imm_arith_type: begin
                    if (f3 == 3'd1 || f3 == 3'd5) begin
                        exp_w[0] = ff7 | ((im & 32'h1F) << 20) | s1 | ff3 | r | 32'h13;
                        exp_e[0] = 32'(im > 32'd31);
                    end else begin
                        exp_w[0] = ifld | s1 | ff3 | r | 32'h13;
                        exp_e[0] = 32'(!in_rng(s, 12));
                    end
                end
                load_type, fence_type, system_type: begin
                    exp_w[0] = ifld | s1 | ff3 | r | ((k == load_type) ? 32'h03 : (k == fence_type) ? 32'h0F : 32'h73);
                    exp_e[0] = 32'(!in_rng(s, 12));
                end
                reg_arith_type: exp_w[0] = ff7 | s2 | s1 | ff3 | r | 32'h33;
                default: begin
                    exp_w[0] = 32'h0;
                    exp_e[0] = 32'd1;
                end
            endcase
        end
    endtask

    task automatic scramble();
        kind      = opcode_t'($urandom_range(0, 11));
        pseudo_li = 1'($urandom_range(0, 1));
        rd        = 5'($urandom);
        rs1       = 5'($urandom);
        rs2       = 5'($urandom);
        funct3    = 3'($urandom);
        funct7    = 7'($urandom);
        imm       = $urandom;
    endtask

    // One full request: accept, then every expected word with stalls (stall<0 => random 0..2).
    task automatic send(input opcode_t k, input logic li, input logic [4:0] f_rd,
                        input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input int stall);
        int st;
        model(k, li, f_rd, f_rs1, f_rs2, f3, f7, im);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        kind = k; pseudo_li = li; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        for (int i = 0; i < exp_n; i++) begin
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int c = 0; c <= st; c++) begin
                check_eq("out_valid", 32'(out_valid), 32'd1);
                check_eq("out_word", out_word, exp_w[i]);
                check_eq("out_err", 32'(out_err), exp_e[i]);
                check_eq("in_ready_busy", 32'(in_ready), 32'd0);
                out_ready = (c == st);
                in_valid  = (c < st) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("valid_after", 32'(out_valid), 32'd0);
        check_eq("ready_after", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] bnd [8];
        bnd = '{32'd2047, 32'hFFFF_F800, 32'd4095, 32'hFFFF_F000, 32'h000F_FFFF,
                32'hFFF0_0000, 32'd31, 32'h7FFF_F800};
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 80)) - 32'd40;
            1:       return bnd[$urandom_range(0, 7)] + 32'($urandom_range(0, 2)) - 32'd1;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_word", out_word, 32'd0);
        check_eq("rst_err", 32'(out_err), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_first_edge", 32'(in_ready), 32'd1);

        send(imm_arith_type, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0);
        send(lui, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678, 1);
        send(lui, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 0);
        send(branch_type, 1'b0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 0);
        send(branch_type, 1'b0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0);
        send(reg_arith_type, 1'b0, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 3);
        send(invalid, 1'b0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1);
        send(store_type, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048, 0);
        send(store_type, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F800, 0);
        send(imm_arith_type, 1'b0, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 32'd32, 0);
        send(jal, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE, 0);
        send(jal, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 0);

        // Reset between the two LI words must drop the pending ADDI.
        @(negedge clk);
        kind = lui; pseudo_li = 1'b1; rd = 5'd5; imm = 32'h1234_5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("li_rst_hi", out_word, 32'h1234_52B7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("li_rst_lo_shown", out_word, 32'h6782_8293);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_word", out_word, 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        send(imm_arith_type, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0);

        for (int n = 0; n < 300; n++) begin
            send(opcode_t'($urandom_range(0, 11)), 1'($urandom_range(0, 3) == 0),
                 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 rand_imm(), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
